// File: rtl/bf_proc.sv
// bf_proc: multicycle Brainfuck CPU core; define BF_STDIN_EN to give ',' a stdin ready/valid handshake.
module bf_proc #(
  parameter int DATA_ADDR_WIDTH  = 16,
  parameter int DATA_VALUE_WIDTH = 32,
  parameter int PROG_ADDR_WIDTH  = 16,
  parameter int PROG_VALUE_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic [PROG_ADDR_WIDTH-1:0]  prog_addr,
  output logic                        prog_ren,
  input  logic [PROG_VALUE_WIDTH-1:0] prog_rval,
  output logic [DATA_ADDR_WIDTH-1:0]  data_addr,
  output logic                        data_ren,
  output logic                        data_wen,
  output logic [DATA_VALUE_WIDTH-1:0] data_wval,
  input  logic [DATA_VALUE_WIDTH-1:0] data_rval,
  output logic [7:0]                  stdout,
  output logic                        stdout_en
`ifdef BF_STDIN_EN
  ,
  input  logic [7:0]                  stdin,
  input  logic                        stdin_valid,
  output logic                        stdin_ready
`endif
);
  typedef enum logic [3:0] {
    FETCH, DECODE, LOAD, LOAD_WAIT, OUT, SCAN_FETCH, SCAN_DECODE, HALT
`ifdef BF_STDIN_EN
    , WAIT_IN
`endif
  } state_t;
  state_t state_q, state_d;
  logic [PROG_ADDR_WIDTH-1:0]  pc_q, pc_d, depth_q, depth_d;
  logic [DATA_ADDR_WIDTH-1:0]  ptr_q, ptr_d;
  logic [DATA_VALUE_WIDTH-1:0] cell_q, cell_d;
  logic [7:0]                  stdout_q, stdout_d, op;
  logic                        dir_q, dir_d, inc, dec;
  assign op        = prog_rval[7:0];
  assign prog_addr = pc_q;
  assign data_addr = ptr_q;
  assign stdout    = stdout_q;
  assign stdout_en = state_q == OUT;
  // dir: 0 scans forward for the matching ']', 1 scans backward for the matching '['
  assign inc = dir_q ? op == 8'h5D : op == 8'h5B;
  assign dec = dir_q ? op == 8'h5B : op == 8'h5D;
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ptr_d     = ptr_q;
    cell_d    = cell_q;
    depth_d   = depth_q;
    dir_d     = dir_q;
    stdout_d  = stdout_q;
    prog_ren  = 1'b0;
    data_ren  = 1'b0;
    data_wen  = 1'b0;
    data_wval = '0;
`ifdef BF_STDIN_EN
    stdin_ready = 1'b0;
`endif
    case (state_q)
      FETCH: begin
        prog_ren = ~reset;
        state_d  = DECODE;
      end
      DECODE: begin
        pc_d    = pc_q + 1'b1;
        state_d = FETCH;
        case (op)
          8'h2B, 8'h2D: begin
            cell_d    = op == 8'h2B ? cell_q + 1'b1 : cell_q - 1'b1;
            data_wen  = 1'b1;
            data_wval = cell_d;
          end
          8'h3E, 8'h3C: begin
            ptr_d   = op == 8'h3E ? ptr_q + 1'b1 : ptr_q - 1'b1;
            state_d = LOAD;
          end
          8'h2E: begin
            stdout_d = cell_q[7:0];
            state_d  = OUT;
          end
          8'h2C: begin
`ifdef BF_STDIN_EN
            pc_d    = pc_q;
            state_d = WAIT_IN;
`else
            cell_d   = '0;
            data_wen = 1'b1;
`endif
          end
          8'h5B: if (cell_q == '0) begin
            depth_d = 1;
            dir_d   = 1'b0;
            state_d = SCAN_FETCH;
          end
          8'h5D: if (cell_q != '0) begin
            depth_d = 1;
            dir_d   = 1'b1;
            pc_d    = pc_q - 1'b1;
            state_d = SCAN_FETCH;
          end
          8'h00: begin
            pc_d    = pc_q;
            state_d = HALT;
          end
          default: ;
        endcase
      end
      LOAD: begin
        data_ren = 1'b1;
        state_d  = LOAD_WAIT;
      end
      LOAD_WAIT: begin
        cell_d  = data_rval;
        state_d = FETCH;
      end
      OUT: state_d = FETCH;
      SCAN_FETCH: begin
        prog_ren = ~reset;
        state_d  = SCAN_DECODE;
      end
      SCAN_DECODE: begin
        depth_d = depth_q + PROG_ADDR_WIDTH'(inc) - PROG_ADDR_WIDTH'(dec);
        if (op == 8'h00) state_d = HALT;
        else if (dec && depth_q == 1) begin
          pc_d    = pc_q + 1'b1;
          state_d = FETCH;
        end else begin
          pc_d    = dir_q ? pc_q - 1'b1 : pc_q + 1'b1;
          state_d = SCAN_FETCH;
        end
      end
`ifdef BF_STDIN_EN
      WAIT_IN: begin
        stdin_ready = 1'b1;
        if (stdin_valid) begin
          cell_d    = DATA_VALUE_WIDTH'(stdin);
          data_wen  = 1'b1;
          data_wval = cell_d;
          pc_d      = pc_q + 1'b1;
          state_d   = FETCH;
        end
      end
`endif
      HALT: ;
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= '0;
      ptr_q    <= '0;
      cell_q   <= '0;
      depth_q  <= '0;
      dir_q    <= 1'b0;
      stdout_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ptr_q    <= ptr_d;
      cell_q   <= cell_d;
      depth_q  <= depth_d;
      dir_q    <= dir_d;
      stdout_q <= stdout_d;
    end
  end
endmodule

// File: tb/tb_bf_proc.sv
// tb_bf_proc: directed and random Brainfuck programs checked against an interpreter model.
module tb_bf_proc;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic [15:0] prog_addr, data_addr;
  logic prog_ren, data_ren, data_wen, stdout_en;
  logic [7:0] prog_rval, stdout;
  logic [31:0] data_wval, data_rval;
  logic [7:0]  rom [0:65535];
  logic [31:0] ram [0:65535];
`ifdef BF_STDIN_EN
  logic [7:0] stdin = 8'h00;
  logic stdin_valid = 1'b1, stdin_ready;
  localparam int COMMA_LAT = 3;
`else
  localparam int COMMA_LAT = 2;
`endif
  bf_proc dut (
    .clk(clk), .reset(reset),
    .prog_addr(prog_addr), .prog_ren(prog_ren), .prog_rval(prog_rval),
    .data_addr(data_addr), .data_ren(data_ren), .data_wen(data_wen),
    .data_wval(data_wval), .data_rval(data_rval),
    .stdout(stdout), .stdout_en(stdout_en)
`ifdef BF_STDIN_EN
    , .stdin(stdin), .stdin_valid(stdin_valid), .stdin_ready(stdin_ready)
`endif
  );
  always @(posedge clk) begin
    if (prog_ren) prog_rval <= rom[prog_addr];
    if (data_wen) ram[data_addr] <= data_wval;
    if (data_ren) data_rval <= ram[data_addr];
  end
  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  byte unsigned prog[$];
  logic [31:0] m_mem [int];
  byte unsigned m_out[$];
  int m_last, m_fetch, first_load;
  bit m_halt;
  function automatic byte unsigned op_at(int j);
    return (j < prog.size()) ? prog[j] : 8'd0;
  endfunction
  task automatic set_prog(input string s);
    prog.delete();
    for (int i = 0; i < s.len(); i++) prog.push_back(s[i]);
  endtask
  // Interpreter: m_last is the cycle of the final (halting) fetch after reset release
  task automatic model();
    int pc = 0, t = 0, d, j;
    logic [15:0] ptr = 0;
    byte unsigned op;
    logic [31:0] c;
    m_mem.delete(); m_out.delete(); m_fetch = 0; m_halt = 0;
    while (t < 4000) begin
      op = op_at(pc);
      m_fetch++;
      if (op == 0) begin m_halt = 1; m_last = t; return; end
      c = m_mem.exists(int'(ptr)) ? m_mem[int'(ptr)] : 0;
      case (op)
        "+": begin m_mem[int'(ptr)] = c + 1; t += 2; end
        "-": begin m_mem[int'(ptr)] = c - 1; t += 2; end
        ">": begin ptr++; t += 4; end
        "<": begin ptr--; t += 4; end
        ".": begin m_out.push_back(c[7:0]); t += 3; end
        ",": begin m_mem[int'(ptr)] = 0; t += COMMA_LAT; end
        "[", "]": begin
          t += 2;
          if ((op == "[") == (c == 0)) begin
            d = 1;
            j = (op == "[") ? pc + 1 : (pc - 1) & 'hFFFF;
            while (t < 4000) begin
              m_fetch++;
              if (op_at(j) == 0) begin m_halt = 1; m_last = t; return; end
              t += 2;
              if (op_at(j) == op) d++;
              else if (op_at(j) == "[" || op_at(j) == "]") d--;
              if (d == 0) break;
              j = (op == "[") ? (j + 1) & 'hFFFF : (j - 1) & 'hFFFF;
            end
            pc = j;
          end
        end
        default: t += 2;
      endcase
      pc = (pc + 1) & 'hFFFF;
    end
  endtask
  task automatic load_mem();
    for (int i = 0; i < 65536; i++) begin rom[i] = 0; ram[i] = 0; end
    for (int i = 0; i < prog.size(); i++) rom[i] = prog[i];
  endtask
  task automatic start(input string name);
    reset = 1;
    load_mem();
    repeat (2) @(posedge clk);
    #1;
    check({name, ".rst_en"}, {prog_ren, data_ren, data_wen, stdout_en}, 0);
    check({name, ".rst_out"}, {stdout, prog_addr, data_addr}, 0);
    check({name, ".rst_wval"}, data_wval, 0);
    @(posedge clk);
    #2 reset = 0;
  endtask
  task automatic run(input string name);
    int cyc = 0, idle = 0, fetch = 0, last = -1;
    byte unsigned outq[$];
    model();
    start(name);
    first_load = -1;
    while (idle < 8 && cyc < m_last + 64) begin
      @(negedge clk);
      if (prog_ren) begin fetch++; last = cyc; idle = 0; end else idle++;
      if (stdout_en) outq.push_back(stdout);
      if (data_ren && first_load < 0) first_load = data_addr;
      if (data_ren || data_wen) check({name, ".ram_excl"}, data_ren & data_wen, 0);
      cyc++;
    end
    check({name, ".halted"}, idle >= 8, 1);
    check({name, ".fetches"}, fetch, m_fetch);
    check({name, ".last_fetch_cyc"}, last, m_last);
    check({name, ".n_out"}, outq.size(), m_out.size());
    for (int i = 0; i < m_out.size(); i++)
      if (i < outq.size()) check($sformatf("%s.out%0d", name, i), outq[i], m_out[i]);
    if (m_out.size() > 0) check({name, ".stdout_hold"}, stdout, m_out[$]);
    foreach (m_mem[k]) check($sformatf("%s.mem[%0h]", name, k), ram[k], m_mem[k]);
  endtask
  task automatic gen();
    string alpha = "+-<>.,#";
    int open = 0;
    prog.delete();
    for (int k = 0; k < $urandom_range(6, 30); k++) begin
      case ($urandom_range(0, 9))
        6: begin prog.push_back("["); prog.push_back("-"); prog.push_back("]"); end
        7: if (open < 2) begin prog.push_back("["); open++; end
        8: if (open > 0) begin prog.push_back("]"); open--; end
        9: prog.push_back("+");
        default: prog.push_back(alpha[$urandom_range(0, 6)]);
      endcase
    end
    while (open > 0) begin prog.push_back("]"); open--; end
  endtask
  initial begin
    bit seen;
    set_prog("+++.");
    run("p1");
    check("p1.mem0", ram[0], 3);
    set_prog(">++<-.");
    run("p2");
    check("p2.mem1", ram[1], 2);
    check("p2.mem0", ram[0], 32'hFFFFFFFF);
    check("p2.stdout", stdout, 8'hFF);
    set_prog("++++++++[>++++++++<-]>+.");
    run("p3");
    check("p3.stdout", stdout, 8'h41);
    check("p3.mem0", ram[0], 0);
    check("p3.mem1", ram[1], 65);
    set_prog("[+++.].");
    run("p4");
    check("p4.stdout", stdout, 0);
    set_prog("<.");
    run("p5");
    check("p5.load_addr", first_load, 32'hFFFF);
    for (int r = 0; r < 15; r++) begin
      for (int a = 0; a < 50; a++) begin
        gen();
        model();
        if (m_halt) break;
      end
      if (m_halt) run($sformatf("rnd%0d", r));
    end
    set_prog("+++..");
    start("ar");
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = stdout_en;
    end
    check("ar.strobe_seen", seen, 1);
    #1 reset = 1;
    #1;
    check("ar.en_drop", stdout_en, 0);
    check("ar.rst_stdout", stdout, 0);
    check("ar.rst_ren", prog_ren, 0);
    @(posedge clk);
    #2 reset = 0;
    #1;
    check("ar.pc0", prog_addr, 0);
    check("ar.fetch", prog_ren, 1);
    check("ar.mem_kept", ram[0], 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
